// File: rtl/msrv_32_pipe_stage_reg_if.sv
// Handshake bundle for one msrv_32 inter-stage pipeline register.
// The slave side is the stage itself; the master side is the surrounding
// logic that feeds it from upstream and drains it downstream.
interface msrv_32_pipe_stage_reg_if #(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) ();

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              flush_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [CNT_W-1:0]  stall_cnt;

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_ctrl,
      input  flush_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_ctrl,
      output stall_cnt
   );

   modport master (
      output in_valid,
      output in_data,
      output in_ctrl,
      output flush_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_ctrl,
      input  stall_cnt
   );

endinterface

// File: rtl/msrv_32_pipe_stage_reg.sv
// Inter-stage pipeline register for the msrv_32 core.
// Holds a payload plus side-effecting control bits behind a valid/ready
// handshake. With SKID=1 a second entry absorbs the cycle in which the
// downstream stalls, so in_ready comes straight from a flop; with SKID=0 a
// single entry is used and in_ready is combinational from out_ready.
// A branch flush empties the stage and drops the incoming entry. Control bits
// are masked whenever the head slot is invalid so a dead slot can never fire
// a register-file or CSR write.
module msrv_32_pipe_stage_reg #(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 8,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic                   ms_risc32_mp_clk_in,
   input  logic                   ms_risc32_mp_rst_in,
   msrv_32_pipe_stage_reg_if.slave bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [DATA_W-1:0] main_data_reg;
   logic [DATA_W-1:0] main_data_next;
   logic [CTRL_W-1:0] main_ctrl_reg;
   logic [CTRL_W-1:0] main_ctrl_next;
   logic [DATA_W-1:0] skid_data_reg;
   logic [DATA_W-1:0] skid_data_next;
   logic [CTRL_W-1:0] skid_ctrl_reg;
   logic [CTRL_W-1:0] skid_ctrl_next;
   logic [CNT_W-1:0]  stall_cnt_reg;

   logic              in_ready_int;
   logic              out_valid_int;
   logic              xfer_in;
   logic              xfer_out;

   assign out_valid_int = (state_reg != ST_EMPTY);
   assign xfer_in       = bus.in_valid & in_ready_int;
   assign xfer_out      = out_valid_int & bus.out_ready;

   // The ready source differs per variant: a flop in skid mode, otherwise
   // "slot free or being drained this cycle".
   generate
      if (SKID != 0) begin : g_skid_ready
         logic ready_reg;

         // Registered ready: deassert exactly when the next state is full.
         always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
            if (ms_risc32_mp_rst_in) begin
               ready_reg <= 1'b1;
            end else begin
               ready_reg <= (state_next != ST_TWO);
            end
         end

         assign in_ready_int = ready_reg;
      end else begin : g_comb_ready
         assign in_ready_int = ~out_valid_int | bus.out_ready;
      end
   endgenerate

   // Next-state and datapath steering; flush overrides every other transition.
   always_comb begin
      state_next     = state_reg;
      main_data_next = main_data_reg;
      main_ctrl_next = main_ctrl_reg;
      skid_data_next = skid_data_reg;
      skid_ctrl_next = skid_ctrl_reg;

      if (bus.flush_in) begin
         // Payload is left as-is (don't-care once invalid); control bits are
         // dropped so nothing stale can be re-exposed later.
         state_next     = ST_EMPTY;
         main_ctrl_next = '0;
         skid_ctrl_next = '0;
      end else begin
         case (state_reg)
            ST_EMPTY: begin
               if (xfer_in) begin
                  state_next     = ST_ONE;
                  main_data_next = bus.in_data;
                  main_ctrl_next = bus.in_ctrl;
               end
            end
            ST_ONE: begin
               if (xfer_in && !xfer_out && (SKID != 0)) begin
                  // Head is stuck; park the newcomer behind it.
                  state_next     = ST_TWO;
                  skid_data_next = bus.in_data;
                  skid_ctrl_next = bus.in_ctrl;
               end else if (xfer_in) begin
                  // Head leaves as the newcomer arrives (always the case
                  // for a single-entry stage, whose ready implies drain).
                  main_data_next = bus.in_data;
                  main_ctrl_next = bus.in_ctrl;
               end else if (xfer_out) begin
                  state_next = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (xfer_out) begin
                  state_next     = ST_ONE;
                  main_data_next = skid_data_reg;
                  main_ctrl_next = skid_ctrl_reg;
               end
            end
            default: begin
               state_next = ST_EMPTY;
            end
         endcase
      end
   end

   // Occupancy and entry storage; reset wipes every entry immediately.
   always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
      if (ms_risc32_mp_rst_in) begin
         state_reg     <= ST_EMPTY;
         main_data_reg <= '0;
         main_ctrl_reg <= '0;
         skid_data_reg <= '0;
         skid_ctrl_reg <= '0;
      end else begin
         state_reg     <= state_next;
         main_data_reg <= main_data_next;
         main_ctrl_reg <= main_ctrl_next;
         skid_data_reg <= skid_data_next;
         skid_ctrl_reg <= skid_ctrl_next;
      end
   end

   // Count back-pressure cycles, sticking at all-ones; flush does not clear it.
   always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
      if (ms_risc32_mp_rst_in) begin
         stall_cnt_reg <= '0;
      end else if (out_valid_int && !bus.out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
         stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
   end

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = out_valid_int;
   assign bus.out_data  = main_data_reg;
   assign bus.out_ctrl  = main_ctrl_reg & {CTRL_W{out_valid_int}};
   assign bus.stall_cnt = stall_cnt_reg;

endmodule
